// File: rtl/seven_segment_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display driver.
package seven_segment_pkg;

    localparam int MAX_DIGITS = 16;

    // All cathodes released: segments and decimal point dark.
    localparam logic [7:0] CATHODE_OFF = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Ceiling log2, usable in constant expressions.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    // Mask with the low n anode bits set (all digits disabled).
    function automatic logic [MAX_DIGITS-1:0] ANODE_OFF(input int unsigned n);
        logic [MAX_DIGITS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational hex nibble + decimal point to active-low cathode pattern.
module ssd_hex_decoder
    import seven_segment_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] cathode
);

    // Decimal point is active-low in bit 7, segments below it.
    always_comb begin
        cathode = {~dp, SEG_LUT[nibble]};
    end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed common-anode N-digit display scanner with double-buffered
// digit data, per-digit blank/blink/dp, PWM brightness and a dead cycle at
// the start of each digit slot.
module seven_segment_mux
    import seven_segment_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int CLK_PER      = 10,
    parameter int REFR_RATE    = 1000,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 250,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic [4*NUM_DIGITS-1:0] encoded,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    load,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [7:0]              cathode,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_tick
);

    localparam longint DC_RAW = 64'sd1_000_000_000 /
        (longint'(CLK_PER) * longint'(REFR_RATE) * longint'(NUM_DIGITS));
    localparam int DIGIT_CYCLES = (DC_RAW < 1) ? 1 : int'(DC_RAW);
    localparam int SLOT_W  = (DIGIT_CYCLES > 1) ? clog2(DIGIT_CYCLES) : 1;
    localparam int FRAME_W = (BLINK_FRAMES > 1) ? clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]     SLOT_LAST     = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [IDX_W-1:0]      DIGIT_LAST    = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0]    FRAME_LAST    = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = NUM_DIGITS'(ANODE_OFF(NUM_DIGITS));
    localparam longint                PWM_MOD       = 64'sd1 <<< BRIGHT_W;

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [IDX_W-1:0]        digit_q, digit_d;
    logic [FRAME_W-1:0]      frame_q, frame_d;
    logic                    phase_q, phase_d;
    logic                    frame_tick_q, frame_tick_d;

    logic [4*NUM_DIGITS-1:0] pend_enc_q, pend_enc_d, act_enc_q, act_enc_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
    logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;

    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [7:0]              cathode_q, cathode_d;

    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    dark;
    logic                    in_pwm;
    logic                    lit;
    logic [7:0]              dec_cathode;

    // Slot / digit / blink-frame counters; frame_tick is registered so it
    // lines up with the counter state it describes and is 0 in reset.
    always_comb begin
        slot_d  = slot_q;
        digit_d = digit_q;
        frame_d = frame_q;
        phase_d = phase_q;
        if (slot_q == SLOT_LAST) begin
            slot_d  = '0;
            digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + IDX_W'(1);
        end else begin
            slot_d = slot_q + SLOT_W'(1);
        end
        if (frame_tick_q) begin
            if (frame_q == FRAME_LAST) begin
                frame_d = '0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + FRAME_W'(1);
            end
        end
        frame_tick_d = (slot_d == SLOT_LAST) && (digit_d == DIGIT_LAST);
    end

    // Pending captures every load; active takes the old pending at frame end.
    always_comb begin
        pend_enc_d   = load ? encoded : pend_enc_q;
        pend_dp_d    = load ? dp      : pend_dp_q;
        pend_blank_d = load ? blank   : pend_blank_q;
        pend_blink_d = load ? blink   : pend_blink_q;
        act_enc_d    = frame_tick_q ? pend_enc_q   : act_enc_q;
        act_dp_d     = frame_tick_q ? pend_dp_q    : act_dp_q;
        act_blank_d  = frame_tick_q ? pend_blank_q : act_blank_q;
        act_blink_d  = frame_tick_q ? pend_blink_q : act_blink_q;
    end

    // Lit decision for the current slot position; slot cycle 0 is always dark.
    always_comb begin
        cur_nib = act_enc_q[{digit_q, 2'b00} +: 4];
        cur_dp  = act_dp_q[digit_q];
        dark    = act_blank_q[digit_q] | (act_blink_q[digit_q] & phase_q);
        in_pwm  = (longint'(slot_q) % PWM_MOD) < longint'(brightness);
        lit     = (slot_q != '0) && !dark && ((&brightness) || in_pwm);
        anode_d   = lit ? ~(NUM_DIGITS'(1) << digit_q) : ANODE_ALL_OFF;
        cathode_d = lit ? dec_cathode : CATHODE_OFF;
    end

    ssd_hex_decoder u_dec (
        .nibble  (cur_nib),
        .dp      (cur_dp),
        .cathode (dec_cathode)
    );

    // All state; reset darkens the display asynchronously.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            slot_q       <= '0;
            digit_q      <= '0;
            frame_q      <= '0;
            phase_q      <= 1'b0;
            frame_tick_q <= 1'b0;
            pend_enc_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '1;
            pend_blink_q <= '0;
            act_enc_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            act_blink_q  <= '0;
            anode_q      <= ANODE_ALL_OFF;
            cathode_q    <= CATHODE_OFF;
        end else begin
            slot_q       <= slot_d;
            digit_q      <= digit_d;
            frame_q      <= frame_d;
            phase_q      <= phase_d;
            frame_tick_q <= frame_tick_d;
            pend_enc_q   <= pend_enc_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_blink_q <= pend_blink_d;
            act_enc_q    <= act_enc_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            act_blink_q  <= act_blink_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
        end
    end

    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign digit_idx  = digit_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_segment_mux.sv
// Self-checking bench for seven_segment_mux: 4 digits, 16-cycle slots,
// 2-frame blink half-period, checked against a cycle-count based model.
module tb_seven_segment_mux;

    localparam int N  = 4;
    localparam int DC = 16;
    localparam int FR = N * DC;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic [15:0]   encoded = '0;
    logic [3:0]    dp = '0, blank = '0, blink = '0, brightness = '0;
    logic          load = 1'b0;
    logic [3:0]    anode;
    logic [7:0]    cathode;
    logic [1:0]    digit_idx;
    logic          frame_tick;

    int total = 0;
    int bad   = 0;
    int unsigned t = 0;

    // Reference model state: pending/active buffers as seen by the display.
    logic [15:0] m_pend_enc, m_act_enc;
    logic [3:0]  m_pend_dp, m_act_dp, m_pend_blank, m_act_blank, m_pend_blink, m_act_blink;

    logic [6:0] seg_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    seven_segment_mux #(
        .NUM_DIGITS   (4),
        .CLK_PER      (10),
        .REFR_RATE    (1_562_500),
        .BRIGHT_W     (4),
        .BLINK_FRAMES (2)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .encoded    (encoded),
        .dp         (dp),
        .blank      (blank),
        .blink      (blink),
        .brightness (brightness),
        .load       (load),
        .anode      (anode),
        .cathode    (cathode),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 Clk = ~Clk;

    task automatic model_reset();
        t = 0;
        m_pend_enc = '0; m_act_enc = '0;
        m_pend_dp = '0;  m_act_dp = '0;
        m_pend_blank = '1; m_act_blank = '1;
        m_pend_blink = '0; m_act_blink = '0;
    endtask

    // One clock: predict the output for cycle t, advance the model, check.
    task automatic cycle();
        int unsigned c, d, fr;
        logic ph, dark, lit;
        logic [3:0] nib;
        logic [3:0] ea;
        logic [7:0] ec;
        logic [1:0] ed;
        logic       ef;
        c  = t % DC;
        d  = (t / DC) % N;
        fr = t / FR;
        ph = ((fr / 2) % 2) == 1;
        nib  = m_act_enc[d*4 +: 4];
        dark = m_act_blank[d] || (m_act_blink[d] && ph);
        lit  = (c != 0) && !dark && (brightness == 4'hF || c < 32'(brightness));
        ea = lit ? ~(4'b0001 << d) : 4'hF;
        ec = lit ? {~m_act_dp[d], seg_tab[nib]} : 8'hFF;
        if (t % FR == FR - 1) begin
            m_act_enc = m_pend_enc; m_act_dp = m_pend_dp;
            m_act_blank = m_pend_blank; m_act_blink = m_pend_blink;
        end
        if (load) begin
            m_pend_enc = encoded; m_pend_dp = dp;
            m_pend_blank = blank; m_pend_blink = blink;
        end
        @(posedge Clk); #1;
        t++;
        ed = 2'((t / DC) % N);
        ef = (t % FR) == FR - 1;
        total++;
        if (anode !== ea) begin
            bad++; $display("FAIL anode t=%0d got=%h exp=%h", t, anode, ea);
        end
        total++;
        if (cathode !== ec) begin
            bad++; $display("FAIL cathode t=%0d got=%h exp=%h", t, cathode, ec);
        end
        total++;
        if (digit_idx !== ed) begin
            bad++; $display("FAIL digit_idx t=%0d got=%0d exp=%0d", t, digit_idx, ed);
        end
        total++;
        if (frame_tick !== ef) begin
            bad++; $display("FAIL frame_tick t=%0d got=%b exp=%b", t, frame_tick, ef);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_to(input int unsigned pos);
        for (int i = 0; i < FR && (t % FR) != pos; i++) cycle();
    endtask

    task automatic do_load(input logic [15:0] e, input logic [3:0] p,
                           input logic [3:0] bl, input logic [3:0] bk);
        encoded = e; dp = p; blank = bl; blink = bk; load = 1'b1;
        cycle();
        load = 1'b0;
        encoded = 16'($urandom); dp = 4'($urandom); blank = 4'($urandom); blink = 4'($urandom);
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        total++;
        if (anode !== 4'hF) begin bad++; $display("FAIL reset_anode got=%h exp=F", anode); end
        total++;
        if (cathode !== 8'hFF) begin bad++; $display("FAIL reset_cathode got=%h exp=FF", cathode); end
        total++;
        if (digit_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", digit_idx); end
        total++;
        if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
        model_reset();
        Reset_n = 1'b1;
        run(2 * FR);
    endtask

    task automatic test_static();
        brightness = 4'hF;
        do_load(16'h3210, 4'h0, 4'h0, 4'h0);
        run_to(0);
        run(FR);
    endtask

    task automatic test_dp();
        do_load(16'hFEDC, 4'b0100, 4'h0, 4'h0);
        run_to(0);
        run(FR + 5);
    endtask

    task automatic test_brightness();
        int cnt [N];
        for (int k = 0; k < 2; k++) begin
            brightness = (k == 0) ? 4'h4 : 4'h0;
            run_to(0);
            for (int i = 0; i < N; i++) cnt[i] = 0;
            for (int i = 0; i < FR; i++) begin
                cycle();
                if (anode != 4'hF) cnt[((t - 1) / DC) % N]++;
            end
            for (int i = 0; i < N; i++) begin
                total++;
                if (cnt[i] != ((k == 0) ? 3 : 0)) begin
                    bad++;
                    $display("FAIL pwm_count b=%0d digit=%0d got=%0d exp=%0d",
                             brightness, i, cnt[i], (k == 0) ? 3 : 0);
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            brightness = 4'($urandom);
            run(DC * 3 + 1);
        end
        brightness = 4'hF;
    endtask

    task automatic test_tear_free();
        run_to(20);
        do_load(16'hA5C7, 4'b1010, 4'h0, 4'h0);
        run_to(FR - 1);
        do_load(16'h9B4E, 4'b0011, 4'h0, 4'h0);
        run(2 * FR);
    endtask

    task automatic test_blink();
        do_load(16'h8421, 4'h0, 4'h0, 4'b0001);
        run(6 * FR);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            brightness = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
            run($urandom_range(1, 70));
            do_load(16'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end
        run(2 * FR);
    endtask

    task automatic test_reset_mid();
        brightness = 4'hF;
        do_load(16'h0123, 4'h0, 4'h0, 4'h0);
        run_to(0);
        run(DC + 6);
        #2;
        Reset_n = 1'b0;
        #1;
        total++;
        if (anode !== 4'hF) begin bad++; $display("FAIL midreset_anode got=%h exp=F", anode); end
        total++;
        if (cathode !== 8'hFF) begin bad++; $display("FAIL midreset_cathode got=%h exp=FF", cathode); end
        total++;
        if (digit_idx !== 2'd0) begin bad++; $display("FAIL midreset_idx got=%0d exp=0", digit_idx); end
        @(posedge Clk); #1;
        model_reset();
        Reset_n = 1'b1;
        run(FR);
        do_load(16'h7E5D, 4'b1001, 4'h0, 4'h0);
        run(2 * FR);
    endtask

    initial begin
        test_reset();
        test_static();
        test_dp();
        test_brightness();
        test_tear_free();
        test_blink();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
